dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive denied loader cycles before a forced loader grant.
REQ-002 Parameter ADDR_W, default 7: word-address width of the data RAM (128 words).
REQ-003 The following ports SHALL exist:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_mem_readmem  in  1  pipeline load request.
- ex_mem_writemem  in  1  pipeline store request.
- ex_mem_wbvalue  in  32  pipeline byte address (ALU result).
- ex_mem_regb  in  32  pipeline store data.
- mem_ram_load  in  1  init mode: loader owns RAM exclusively.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  32  loader write data.
- ld_ack  out  1  loader write performed this cycle.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_wre  out  1  RAM write enable.
- ram_rdata  in  32  RAM synchronous read data, valid the cycle after the address.
- mem_stall  out  1  pipeline request not serviced this cycle; hold EX/MEM.
- pipe_rdata  out  32  load data to writeback.
- pipe_rvalid  out  1  pipe_rdata valid.
- mem_fault  out  1  one-cycle pulse: misaligned or out-of-range pipeline access.

Function
REQ-004 pipe_req SHALL be ex_mem_readmem OR ex_mem_writemem; when both are high, the request SHALL be treated as a store.
REQ-005 Pipeline word address SHALL be ex_mem_wbvalue[ADDR_W+1:2]; an address with [1:0]!=0 or [31:ADDR_W+2]!=0 is illegal.
REQ-006 An illegal pipeline request SHALL get no RAM access, no stall, and mem_fault=1 in the following cycle only.
REQ-007 FSM states SHALL be NORM, STARVED and INIT; the reset state is NORM.
REQ-008 NORM: a legal pipe_req is granted; ld_req is granted only when pipe_req=0 or the pipeline request is illegal.
REQ-009 starve_cnt SHALL increment, saturating, for each cycle ld_req=1 and is denied; it clears on a loader grant or when ld_req=0.
REQ-010 NORM->STARVED when starve_cnt reaches STARVE_LIMIT with ld_req still high.
REQ-011 STARVED: with ld_req=1, grant the loader, assert mem_stall if pipe_req, return to NORM and clear starve_cnt; with ld_req=0, return to NORM with no stall.
REQ-012 Any state->INIT when mem_ram_load=1, taking effect in the same cycle; INIT->NORM when mem_ram_load=0, with starve_cnt cleared.
REQ-013 INIT: the loader is granted whenever ld_req=1, and mem_stall=pipe_req; illegal pipeline requests still pulse mem_fault.
REQ-014 Grant outputs (ram_addr, ram_wdata, ram_wre, ld_ack, mem_stall) SHALL be combinational from current state and inputs. With no grant: ram_wre=0 and ram_addr=0.
REQ-015 Pipeline store grant: ram_wre=1, ram_wdata=ex_mem_regb. Loader grant: ram_wre=1, ram_addr=ld_addr, ram_wdata=ld_data, ld_ack=1.
REQ-016 Pipeline load grant: ram_wre=0. pipe_rvalid=1 in the next cycle, with pipe_rdata=ram_rdata in that cycle; pipe_rvalid=0 otherwise.
REQ-017 A stalled pipeline request SHALL be re-arbitrated every cycle until granted; the arbiter holds no copy of it.

Reset
REQ-018 While reset=1: state=NORM, starve_cnt=0, mem_fault=0, pipe_rvalid=0, ld_ack=0, ram_wre=0, mem_stall=0, ram_addr=0, pipe_rdata=0.
REQ-019 Reset mid-operation SHALL drop any pending pipe_rvalid or mem_fault pulse; no RAM write occurs in a reset cycle.

Structure
REQ-020 The shared header SHALL hold the FSM state encodings, the default STARVE_LIMIT and RAM depth, and the address-legality bit ranges.
REQ-021 The saturating starvation counter SHALL be a sub-module, dmem_starve_ctr; the FSM and muxing stay in dmem_arbiter.

Verification
REQ-022 Scenario: pipeline store to 0x10 with data 0xDEADBEEF, then load from 0x10 -> ram_addr=4, ram_wre=1, then pipe_rvalid=1 with pipe_rdata=0xDEADBEEF one cycle after the load.
REQ-023 Scenario: ld_req held while pipe_req is held for 6 cycles (STARVE_LIMIT=4) -> 4 denied cycles, then ld_ack=1 and mem_stall=1 for exactly one cycle, then the pipeline resumes.
REQ-024 Scenario: pipeline load from 0x13, and separately from 0x200 -> no RAM access, mem_stall=0, one-cycle mem_fault each.
REQ-025 Scenario: mem_ram_load=1 with a loader write of ld_addr=5, ld_data=0x1234 while pipe_req=1 -> ld_ack=1 and mem_stall=1. After mem_ram_load falls, a pipeline load from 0x14 returns 0x1234.
REQ-026 Scenario: reset asserted in the cycle after a granted load -> pipe_rvalid=0, state NORM, starve_cnt=0.
REQ-027 Scenario: readmem and writemem both set to 0x8, with regb=0xA5A5A5A5 -> treated as a store: ram_wre=1, and pipe_rvalid stays 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter_pkg
// Brief  : Shared constants for the data-memory arbiter: state encodings,
//          default sizing and pipeline address-legality bit ranges.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int c_DEF_STARVE_LIMIT = 4;
    localparam int c_DEF_ADDR_W       = 7;
    localparam int c_RAM_DEPTH        = 1 << c_DEF_ADDR_W;

    // Byte-address fields: [1:0] must be zero, word index starts at bit 2
    localparam int c_ALIGN_LSB = 0;
    localparam int c_ALIGN_MSB = 1;
    localparam int c_WORD_LSB  = 2;

    localparam logic [1:0] c_ST_NORM    = 2'd0;
    localparam logic [1:0] c_ST_STARVED = 2'd1;
    localparam logic [1:0] c_ST_INIT    = 2'd2;

    // Legal when word aligned and every bit above the word index is zero
    function automatic logic addr_legal(input logic [31:0] byte_addr, input int addr_w);
        logic [31:0] hi;
        hi = byte_addr >> (addr_w + c_WORD_LSB);
        return (byte_addr[c_ALIGN_MSB:c_ALIGN_LSB] == 2'b00) && (hi == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module : dmem_starve_ctr
// Brief  : Saturating count of consecutive denied loader cycles.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Single-port data RAM arbiter between the pipeline MEM stage and
//          a program loader, with starvation relief and an init mode.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT,
    parameter int ADDR_W       = c_DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_mem_readmem,
    input  logic              ex_mem_writemem,
    input  logic [31:0]       ex_mem_wbvalue,
    input  logic [31:0]       ex_mem_regb,
    input  logic              mem_ram_load,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wre,
    input  logic [31:0]       ram_rdata,
    output logic              mem_stall,
    output logic [31:0]       pipe_rdata,
    output logic              pipe_rvalid,
    output logic              mem_fault
);

    localparam int               c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_HIT = c_CNT_W'(STARVE_LIMIT - 1);

    logic              w_pipe_req;
    logic              w_is_store;
    logic              w_legal;
    logic              w_pipe_valid;
    logic [ADDR_W-1:0] w_word_addr;
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        w_eff_state;
    logic              w_pipe_grant;
    logic              w_ld_grant;
    logic              w_stall;
    logic [c_CNT_W-1:0] w_cnt;
    logic              r_rvalid;
    logic              r_fault;

    assign w_pipe_req   = ex_mem_readmem | ex_mem_writemem;
    assign w_is_store   = ex_mem_writemem;
    assign w_legal      = addr_legal(ex_mem_wbvalue, ADDR_W);
    assign w_pipe_valid = w_pipe_req & w_legal;
    assign w_word_addr  = ex_mem_wbvalue[ADDR_W+1:c_WORD_LSB];

    // Init mode preempts arbitration in the very cycle it is requested
    assign w_eff_state  = mem_ram_load ? c_ST_INIT : r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_NORM;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The counter is at LIMIT-1 when this denial makes it reach LIMIT
    always_comb begin
        w_next_state = r_state;
        if (mem_ram_load) begin
            w_next_state = c_ST_INIT;
        end else begin
            case (r_state)
                c_ST_NORM: begin
                    if (ld_req && !w_ld_grant && (w_cnt == c_HIT)) begin
                        w_next_state = c_ST_STARVED;
                    end
                end
                c_ST_STARVED: w_next_state = c_ST_NORM;
                c_ST_INIT:    w_next_state = c_ST_NORM;
                default:      w_next_state = c_ST_NORM;
            endcase
        end
    end

    // Illegal pipeline requests are never stalled; they only raise a fault
    always_comb begin
        w_pipe_grant = 1'b0;
        w_ld_grant   = 1'b0;
        w_stall      = 1'b0;
        if (!reset) begin
            case (w_eff_state)
                c_ST_INIT: begin
                    w_ld_grant = ld_req;
                    w_stall    = w_pipe_valid;
                end
                c_ST_STARVED: begin
                    if (ld_req) begin
                        w_ld_grant = 1'b1;
                        w_stall    = w_pipe_valid;
                    end else begin
                        w_pipe_grant = w_pipe_valid;
                    end
                end
                default: begin
                    w_pipe_grant = w_pipe_valid;
                    w_ld_grant   = ld_req & ~w_pipe_valid;
                end
            endcase
        end
    end

    assign ram_wre   = w_ld_grant | (w_pipe_grant & w_is_store);
    assign ram_addr  = w_ld_grant   ? ld_addr     :
                       w_pipe_grant ? w_word_addr : '0;
    assign ram_wdata = w_ld_grant                  ? ld_data     :
                       (w_pipe_grant & w_is_store) ? ex_mem_regb : '0;
    assign ld_ack    = w_ld_grant;
    assign mem_stall = w_stall;

    dmem_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (c_CNT_W)
    ) u_starve_ctr (
        .clock (clock),
        .reset (reset),
        .inc   (ld_req & ~w_ld_grant),
        .clr   (~ld_req | w_ld_grant),
        .cnt   (w_cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_rvalid <= w_pipe_grant & ~w_is_store;
            r_fault  <= w_pipe_req & ~w_legal;
        end
    end

    // Gating with reset drops any pulse still in flight when reset arrives
    assign pipe_rvalid = r_rvalid & ~reset;
    assign mem_fault   = r_fault & ~reset;
    assign pipe_rdata  = pipe_rvalid ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arbiter
// Brief  : Scoreboard bench for dmem_arbiter with a behavioural RAM/arbiter
//          model; directed scenarios followed by randomized traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int LIMIT = 4;
    localparam int AW    = 7;
    localparam int WORDS = 128;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ex_mem_readmem = 1'b0;
    logic          ex_mem_writemem = 1'b0;
    logic [31:0]   ex_mem_wbvalue = '0;
    logic [31:0]   ex_mem_regb = '0;
    logic          mem_ram_load = 1'b0;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;
    logic          ld_ack;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_wre;
    logic [31:0]   ram_rdata = '0;
    logic          mem_stall;
    logic [31:0]   pipe_rdata;
    logic          pipe_rvalid;
    logic          mem_fault;

    always #5 clock = ~clock;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_wbvalue(ex_mem_wbvalue), .ex_mem_regb(ex_mem_regb),
        .mem_ram_load(mem_ram_load), .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_ack(ld_ack), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wre(ram_wre), .ram_rdata(ram_rdata),
        .mem_stall(mem_stall), .pipe_rdata(pipe_rdata),
        .pipe_rvalid(pipe_rvalid), .mem_fault(mem_fault)
    );

    // Synchronous-read RAM attached to the arbiter
    logic [31:0] tb_ram [0:WORDS-1];
    always @(posedge clock) begin
        if (ram_wre) tb_ram[ram_addr] <= ram_wdata;
        ram_rdata <= tb_ram[ram_addr];
    end

    typedef struct {
        bit          rst;
        bit          wre;
        logic [6:0]  addr;
        logic [31:0] wdata;
        bit          ack;
        bit          stall;
        bit          rvalid;
        logic [31:0] rdata;
        bit          rknown;
        bit          fault;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: modes 0=normal 1=starved 2=init
    int          m_mode = 0;
    int          m_denied = 0;
    bit          m_pv = 0;
    logic [31:0] m_pd = '0;
    bit          m_pk = 0;
    bit          m_pf = 0;
    logic [31:0] gmem [WORDS];
    bit          gknown [WORDS];
    bit          last_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] regb, input bit rl, input bit lq,
                       input logic [6:0] la, input logic [31:0] ldd);
        exp_t e;
        bit   pipe, legal, pipe_ok, ld_ok, stall;
        int   word, mode;
        @(posedge clock);
        #1;
        reset = rst; ex_mem_readmem = rd; ex_mem_writemem = wr;
        ex_mem_wbvalue = addr; ex_mem_regb = regb; mem_ram_load = rl;
        ld_req = lq; ld_addr = la; ld_data = ldd;
        e.rst = rst; e.wre = 0; e.addr = '0; e.wdata = '0; e.ack = 0; e.stall = 0;
        e.rvalid = 0; e.rdata = '0; e.rknown = 0; e.fault = 0;
        if (rst) begin
            m_mode = 0; m_denied = 0; m_pv = 0; m_pf = 0; last_stall = 0;
        end else begin
            e.rvalid = m_pv; e.rdata = m_pd; e.rknown = m_pk; e.fault = m_pf;
            pipe  = rd || wr;
            legal = (addr % 4 == 0) && (addr < 32'(4 * WORDS));
            word  = int'(addr / 4) % WORDS;
            mode  = rl ? 2 : m_mode;
            pipe_ok = 0; ld_ok = 0; stall = 0;
            if (mode == 2) begin
                ld_ok = lq; stall = pipe && legal;
            end else if (mode == 1 && lq) begin
                ld_ok = 1; stall = pipe && legal;
            end else begin
                pipe_ok = pipe && legal; ld_ok = lq && !pipe_ok;
            end
            m_pv = pipe_ok && !wr;
            m_pd = gmem[word]; m_pk = gknown[word];
            m_pf = pipe && !legal;
            if (ld_ok) begin
                e.wre = 1; e.addr = la; e.wdata = ldd; e.ack = 1;
                gmem[la] = ldd; gknown[la] = 1;
            end else if (pipe_ok) begin
                e.addr = 7'(word);
                if (wr) begin
                    e.wre = 1; e.wdata = regb; gmem[word] = regb; gknown[word] = 1;
                end
            end
            e.stall = stall;
            last_stall = stall;
            if (lq && !ld_ok) m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
            else              m_denied = 0;
            if (rl) m_mode = 2;
            else if (m_mode == 0 && lq && !ld_ok && m_denied >= LIMIT) m_mode = 1;
            else m_mode = 0;
        end
        q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Monitor: compares the DUT against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ram_wre", 32'(ram_wre), 32'(e.wre));
                chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                if (e.wre) chk("ram_wdata", ram_wdata, e.wdata);
                chk("ld_ack", 32'(ld_ack), 32'(e.ack));
                chk("mem_stall", 32'(mem_stall), 32'(e.stall));
                chk("pipe_rvalid", 32'(pipe_rvalid), 32'(e.rvalid));
                chk("mem_fault", 32'(mem_fault), 32'(e.fault));
                if (e.rvalid && e.rknown) chk("pipe_rdata", pipe_rdata, e.rdata);
                if (e.rst) chk("pipe_rdata_rst", pipe_rdata, 32'h0);
            end
        end
    end

    initial begin
        bit          rd, wr, rl, rst, lq;
        logic [31:0] addr, regb;
        int          k, sel;
        for (int i = 0; i < WORDS; i++) begin
            gmem[i] = '0; gknown[i] = 0;
        end
        rd = 0; wr = 0; rl = 0; addr = '0; regb = '0;

        cyc(1, 0, 0, '0, '0, 0, 0, '0, '0);
        cyc(1, 1, 1, 32'h10, 32'h1, 0, 1, 7'd3, 32'h2);
        // Store then load back
        cyc(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, '0, '0);
        cyc(0, 1, 0, 32'h10, '0, 0, 0, '0, '0);
        idle();
        // Starvation relief
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 32'h20, '0, 0, 1, 7'd9, 32'h55);
        idle();
        // Illegal addresses
        cyc(0, 1, 0, 32'h13, '0, 0, 0, '0, '0);
        idle();
        cyc(0, 1, 0, 32'h200, '0, 0, 0, '0, '0);
        idle();
        // Init mode
        cyc(0, 1, 0, 32'h14, '0, 1, 1, 7'd5, 32'h1234);
        idle();
        cyc(0, 1, 0, 32'h14, '0, 0, 0, '0, '0);
        idle();
        // Reset right after a granted load
        cyc(0, 1, 0, 32'h10, '0, 0, 0, '0, '0);
        cyc(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle();
        // Simultaneous read and write is a store
        cyc(0, 1, 1, 32'h8, 32'hA5A5A5A5, 0, 0, '0, '0);
        idle();
        cyc(0, 1, 0, 32'h8, '0, 0, 0, '0, '0);
        idle();

        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                k  = $urandom_range(0, 9);
                rd = (k < 4);
                wr = (k >= 3 && k < 7);
                sel = $urandom_range(0, 19);
                if (sel == 0)      addr = {23'd0, 7'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                else if (sel == 1) addr = 32'h200 + 32'($urandom_range(0, 255)) * 4;
                else               addr = 32'($urandom_range(0, 15)) * 4;
                regb = $urandom;
            end
            if ($urandom_range(0, 19) == 0) rl = !rl;
            rst = ($urandom_range(0, 99) == 0);
            lq  = ($urandom_range(0, 9) < 7);
            cyc(rst, rd, wr, addr, regb, rl, lq, 7'($urandom_range(0, 15)), $urandom);
        end
        idle();
        idle();

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
